ewma_cov_engine: RTL and testbench
==================================

// Module: ewma_cov_engine
// PURPOSE
//  Time-multiplexed EWMA mean/covariance estimator for N_STOCKS return streams; successor to the fully parallel estimator.
//  One shared MAC walks the P = N_STOCKS*(N_STOCKS+1)/2 upper-triangle pairs, so channel count scales without N^2 multipliers.
//  Adds valid/ready input handshake, per-sample runtime lambda, warm-up tracking, synchronous clear and optional saturation.
//  Sits between the returns pipeline and the risk/portfolio stage.
// PARAMETERS
//  WIDTH     16  signed sample/mean/covariance width, Q(WIDTH-FRACT).FRACT
//  FRACT     8   fractional bits; lambda is unsigned Q1.FRACT
//  N_STOCKS  4   channel count, >= 2
//  WARMUP    8   accepted samples before warm is asserted, >= 1
//  CNT_W     16  sample_count width; counter saturates at 2^CNT_W-1
// PORTS
//  clk        in   1                      clock, all logic on rising edge
//  rst_n      in   1                      asynchronous active-low reset
//  clear      in   1                      synchronous statistics restart
//  valid_in   in   1                      sample offered
//  ready_out  out  1                      engine can accept (state IDLE, clear low)
//  x_in       in   N_STOCKS*WIDTH         signed samples, channel k at [k*WIDTH +: WIDTH]
//  lambda_in  in   FRACT+1                unsigned Q1.FRACT weight; > 2^FRACT clamps to 2^FRACT
//  valid_out  out  1                      one-cycle pulse: cov_out/mean_out updated
//  mean_out   out  N_STOCKS*WIDTH         signed EWMA means
//  cov_out    out  N_STOCKS*N_STOCKS*WIDTH signed cov, [i][j] at [(i*N_STOCKS+j)*WIDTH +: WIDTH]
//  warm       out  1                      sample_count >= WARMUP
//  sample_count out CNT_W                 samples accepted since reset/clear
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE, first=1; means, covs, sample_count, valid_out, warm = 0; ready_out = 0 while rst_n low.
//  - Accept when valid_in && ready_out: latch x_in and clamped lambda L; sample_count++ (saturating). Not accepted while busy; no buffering.
//  - States: IDLE -> SEED (first sample) -> DONE -> IDLE; IDLE -> DEV -> PAIR(P cycles) -> MEAN -> DONE -> IDLE.
//  - SEED: mean[k] <= x[k]; all cov <= 0; first <= 0.
//  - DEV: d[k] <= mean[k] - x[k], WIDTH+1 bits, using pre-update means.
//  - PAIR: one (i,j), j>=i, per cycle, row-major (0,0),(0,1)..(N-1,N-1):
//      cov[i][j] <= ((2^FRACT - L)*cov[i][j]*2^FRACT + L*d[i]*d[j]) >>> 2*FRACT
//      full-precision intermediate (>= 2*WIDTH+2*FRACT+4 bits), arithmetic (floor) shift.
//  - MEAN: mean[k] <= (mean[k]*(2^FRACT - L) + x[k]*L) >>> FRACT; convex, never overflows.
//  - DONE: valid_out = 1 for exactly this cycle; ready_out = 0 in DONE; IDLE next, ready_out = 1.
//  - Latency, accept at t0: first sample valid_out at t0+2; otherwise valid_out at t0+P+3 (N=4: t0+13).
//  - Throughput: one sample per 3 (seed) or P+4 cycles.
//  - Storage upper triangle only; cov_out[j][i] mirrors cov[i][j]. Outputs change only at SEED/PAIR/MEAN writes.
//  - warm registered from sample_count; updates the cycle after accept.
//  - L = 0: stats frozen, valid_out still pulses. L = 2^FRACT: cov = d_i*d_j >>> FRACT, mean = x.
//  - clear: any state -> IDLE next cycle, first=1, means/covs/sample_count/warm = 0; in-flight sample dropped, no valid_out;
//    ready_out = 0 while clear high; clear and valid_in same cycle: clear wins, sample not accepted.
//  - rst_n low mid-PAIR: immediate async reset, no partial valid_out.
// CONFIGURATION
//  EWMA_SAT_EN defined: cov result clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//  EWMA_SAT_EN undefined: cov result takes low WIDTH bits (two's-complement wrap). Means unaffected either way.
// TESTING (WIDTH=16, FRACT=8, N_STOCKS=4, WARMUP=8)
//  1 Seed: reset, x=[256,0,0,0] at t0 -> valid_out at t0+2, mean0=256, all cov=0, sample_count=1.
//  2 Update: then x=[512,0,0,0], L=64 at t1 -> valid_out at t1+13, cov[0][0]=64, mean0=320, others 0.
//  3 Saturation: seed x0=32767, then x0=-32768, L=256 -> cov[0][0]=32767 with EWMA_SAT_EN, 0xFE00 (-512) without.
//  4 Handshake: valid_in held high during PAIR -> ready_out=0, no second accept until IDLE; exactly one valid_out per accept.
//  5 Clear: clear in 5th PAIR cycle -> no valid_out, all stats 0, next sample reseeds (valid_out 2 cycles after accept).
//  6 Warm/symmetry: 8 random samples -> warm rises after 8th accept; cov_out[i][j]==cov_out[j][i] vs golden model.

Source files
------------

// File: rtl/ewma_cov_engine.sv
// Time-multiplexed EWMA mean/covariance estimator over upper-triangle channel pairs.
// Optional EWMA_SAT_EN clamps covariance results instead of wrapping them.
module ewma_cov_engine #(
    parameter int WIDTH    = 16,
    parameter int FRACT    = 8,
    parameter int N_STOCKS = 4,
    parameter int WARMUP   = 8,
    parameter int CNT_W    = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                valid_in,
    output logic                                ready_out,
    input  logic [N_STOCKS*WIDTH-1:0]           x_in,
    input  logic [FRACT:0]                      lambda_in,
    output logic                                valid_out,
    output logic [N_STOCKS*WIDTH-1:0]           mean_out,
    output logic [N_STOCKS*N_STOCKS*WIDTH-1:0]  cov_out,
    output logic                                warm,
    output logic [CNT_W-1:0]                    sample_count
);
    localparam int N  = N_STOCKS;
    localparam int P  = N * (N + 1) / 2;
    localparam int IW = $clog2(N);
    localparam int PW = $clog2(P);
    localparam int LW = FRACT + 1;
    localparam int DW = WIDTH + 1;
    localparam int AW = 2 * WIDTH + 2 * FRACT + 4;
    localparam int MW = WIDTH + FRACT + 3;
    localparam logic [LW-1:0] ONE = LW'(1 << FRACT);

    typedef enum logic [2:0] {IDLE, SEED, DEV, PAIR, MEAN, DONE} state_t;

    state_t state_q, state_d;
    logic   first_q;
    logic [LW-1:0] l_q;
    logic [LW-1:0] om;
    logic signed [WIDTH-1:0] x_q    [N];
    logic signed [DW-1:0]    d_q    [N];
    logic signed [WIDTH-1:0] mean_q [N];
    logic signed [WIDTH-1:0] tri_q  [P];
    logic [IW-1:0] pi_q, pj_q;
    logic [PW-1:0] pk_q;
    logic accept;
    logic [CNT_W-1:0] cnt_nxt;
    logic signed [AW-1:0] prod;
    logic signed [AW-1:0] shifted;
    logic signed [WIDTH-1:0] cov_new;
    logic signed [MW-1:0] msum [N];
    logic signed [WIDTH-1:0] mean_new [N];

    assign ready_out = rst_n && !clear && (state_q == IDLE);
    assign valid_out = (state_q == DONE) && !clear;
    assign accept    = valid_in && ready_out;
    assign cnt_nxt   = (&sample_count) ? sample_count : sample_count + 1'b1;
    assign om        = ONE - l_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = first_q ? SEED : DEV;
            SEED:    state_d = DONE;
            DEV:     state_d = PAIR;
            PAIR:    if (pk_q == PW'(P - 1)) state_d = MEAN;
            MEAN:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    // Full-precision weighted sum; old covariance is pre-scaled to 2*FRACT.
    always_comb begin
        prod = ((AW'($signed({1'b0, om})) * AW'(tri_q[pk_q])) <<< FRACT)
             + AW'($signed({1'b0, l_q})) * AW'(d_q[pi_q]) * AW'(d_q[pj_q]);
        shifted = prod >>> (2 * FRACT);
`ifdef EWMA_SAT_EN
        if (shifted > $signed({{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}}))
            cov_new = {1'b0, {(WIDTH-1){1'b1}}};
        else if (shifted < $signed({{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}}))
            cov_new = {1'b1, {(WIDTH-1){1'b0}}};
        else
            cov_new = WIDTH'(shifted);
`else
        cov_new = WIDTH'(shifted);
`endif
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            msum[k] = MW'(mean_q[k]) * MW'($signed({1'b0, om}))
                    + MW'(x_q[k]) * MW'($signed({1'b0, l_q}));
            mean_new[k] = WIDTH'(msum[k] >>> FRACT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q      <= 1'b1;
            l_q          <= '0;
            pi_q         <= '0;
            pj_q         <= '0;
            pk_q         <= '0;
            sample_count <= '0;
            warm         <= 1'b0;
            for (int k = 0; k < N; k++) begin
                x_q[k]    <= '0;
                d_q[k]    <= '0;
                mean_q[k] <= '0;
            end
            for (int p = 0; p < P; p++) tri_q[p] <= '0;
        end else if (clear) begin
            first_q      <= 1'b1;
            pi_q         <= '0;
            pj_q         <= '0;
            pk_q         <= '0;
            sample_count <= '0;
            warm         <= 1'b0;
            for (int k = 0; k < N; k++) mean_q[k] <= '0;
            for (int p = 0; p < P; p++) tri_q[p] <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < N; k++)
                    x_q[k] <= x_in[k*WIDTH +: WIDTH];
                l_q          <= (lambda_in > ONE) ? ONE : lambda_in;
                sample_count <= cnt_nxt;
                warm         <= (cnt_nxt >= CNT_W'(WARMUP));
            end
            unique case (state_q)
                SEED: begin
                    first_q <= 1'b0;
                    for (int k = 0; k < N; k++) mean_q[k] <= x_q[k];
                    for (int p = 0; p < P; p++) tri_q[p] <= '0;
                end
                DEV: begin
                    pi_q <= '0;
                    pj_q <= '0;
                    pk_q <= '0;
                    for (int k = 0; k < N; k++)
                        d_q[k] <= DW'(mean_q[k]) - DW'(x_q[k]);
                end
                PAIR: begin
                    tri_q[pk_q] <= cov_new;
                    pk_q        <= pk_q + 1'b1;
                    if (pj_q == IW'(N - 1)) begin
                        pi_q <= pi_q + 1'b1;
                        pj_q <= pi_q + 1'b1;
                    end else begin
                        pj_q <= pj_q + 1'b1;
                    end
                end
                MEAN: for (int k = 0; k < N; k++) mean_q[k] <= mean_new[k];
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_mean
        assign mean_out[k*WIDTH +: WIDTH] = mean_q[k];
    end

    // Lower triangle mirrors the stored upper triangle.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            localparam int LO = (i < j) ? i : j;
            localparam int HI = (i < j) ? j : i;
            localparam int K  = LO * N - LO * (LO - 1) / 2 + (HI - LO);
            assign cov_out[(i*N+j)*WIDTH +: WIDTH] = tri_q[K];
        end
    end
endmodule

// File: tb/tb_ewma_cov_engine.sv
// Randomized self-checking bench for ewma_cov_engine against a plain-arithmetic model.
module tb_ewma_cov_engine;
    localparam int W  = 16;
    localparam int F  = 8;
    localparam int N  = 4;
    localparam int WU = 8;
    localparam int CW = 16;
    localparam int P  = N * (N + 1) / 2;

    logic clk = 0;
    logic rst_n = 0;
    logic clear = 0;
    logic valid_in = 0;
    logic ready_out;
    logic [N*W-1:0] x_in = '0;
    logic [F:0] lambda_in = '0;
    logic valid_out;
    logic [N*W-1:0] mean_out;
    logic [N*N*W-1:0] cov_out;
    logic warm;
    logic [CW-1:0] sample_count;

    int n_chk = 0;
    int n_fail = 0;
    int vcount = 0;
    int vexp = 0;

    longint mean_m [N];
    longint cov_m [N][N];
    bit first_m = 1;
    int cnt_m = 0;

    ewma_cov_engine #(.WIDTH(W), .FRACT(F), .N_STOCKS(N),
                      .WARMUP(WU), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .valid_in(valid_in), .ready_out(ready_out),
        .x_in(x_in), .lambda_in(lambda_in),
        .valid_out(valid_out), .mean_out(mean_out),
        .cov_out(cov_out), .warm(warm),
        .sample_count(sample_count));

    always #5 clk = ~clk;

    always @(negedge clk) if (valid_out) vcount++;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint get_mean(input int k);
        logic signed [W-1:0] t;
        t = mean_out[k*W +: W];
        return longint'(t);
    endfunction

    function automatic longint get_cov(input int i, input int j);
        logic signed [W-1:0] t;
        t = cov_out[(i*N+j)*W +: W];
        return longint'(t);
    endfunction

    function automatic longint fix_cov(input longint v);
        logic signed [W-1:0] t;
`ifdef EWMA_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        t = v[W-1:0];
        return longint'(t);
`endif
    endfunction

    task automatic model_clear();
        first_m = 1;
        cnt_m = 0;
        for (int i = 0; i < N; i++) begin
            mean_m[i] = 0;
            for (int j = 0; j < N; j++) cov_m[i][j] = 0;
        end
    endtask

    task automatic model_update(input int xs[N], input int lam);
        longint l, d[N];
        l = (lam > 256) ? 256 : lam;
        if (cnt_m < 65535) cnt_m++;
        if (first_m) begin
            first_m = 0;
            for (int i = 0; i < N; i++) begin
                mean_m[i] = xs[i];
                for (int j = 0; j < N; j++) cov_m[i][j] = 0;
            end
            return;
        end
        for (int i = 0; i < N; i++) d[i] = mean_m[i] - xs[i];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                cov_m[i][j] = fix_cov(((256 - l) * cov_m[i][j] * 256
                              + l * d[i] * d[j]) >>> 16);
        for (int i = 0; i < N; i++)
            mean_m[i] = (mean_m[i] * (256 - l) + longint'(xs[i]) * l) >>> 8;
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s mean%0d", tag, i), get_mean(i), mean_m[i]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                check($sformatf("%s cov%0d%0d", tag, i, j),
                      get_cov(i, j), cov_m[i][j]);
        check({tag, " count"}, longint'(sample_count), longint'(cnt_m));
        check({tag, " warm"}, longint'(warm), longint'(cnt_m >= WU));
    endtask

    // Offers a sample and returns once it is accepted (at #1 after the edge).
    task automatic start_accept(input int xs[N], input int lam,
                                output bit was_first, output bit ok);
        int w;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) x_in[k*W +: W] = xs[k][W-1:0];
        lambda_in = lam[F:0];
        valid_in = 1;
        w = 0;
        while (!ready_out && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        ok = (w < 200);
        if (!ok) begin
            check("ready_timeout", 0, 1);
            valid_in = 0;
            return;
        end
        was_first = first_m;
        model_update(xs, lam);
        @(posedge clk); #1;
    endtask

    task automatic send(input string tag, input int xs[N], input int lam,
                        input int hold);
        bit f, ok;
        int lat;
        start_accept(xs, lam, f, ok);
        if (!ok) return;
        lat = 1;
        for (int h = 0; h < hold; h++) begin
            check({tag, " busy_ready"}, longint'(ready_out), 0);
            check({tag, " busy_count"}, longint'(sample_count),
                  longint'(cnt_m));
            @(posedge clk); #1;
            lat++;
        end
        valid_in = 0;
        while (!valid_out && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, f ? 2 : P + 3);
        vexp++;
        @(posedge clk); #1;
        check({tag, " pulses"}, vcount, vexp);
        compare_all(tag);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int v[N];
        bit f, ok;
        model_clear();
        #12;
        check("rst ready", longint'(ready_out), 0);
        check("rst valid", longint'(valid_out), 0);
        compare_all("rst");
        @(posedge clk); #1;
        rst_n = 1;
        #1;
        check("post_rst ready", longint'(ready_out), 1);

        v = '{256, 0, 0, 0};
        send("seed", v, 64, 0);
        check("seed mean0", get_mean(0), 256);

        v = '{512, 0, 0, 0};
        send("upd", v, 64, 0);
        check("upd cov00", get_cov(0, 0), 64);
        check("upd mean0", get_mean(0), 320);

        v = '{-100, 300, 40, -7};
        send("hold", v, 128, 6);

        // Clear during the fifth pair cycle drops the in-flight sample.
        v = '{1000, -2000, 3000, -4000};
        start_accept(v, 200, f, ok);
        valid_in = 0;
        idle_cycles(5);
        clear = 1;
        #1;
        check("clr ready", longint'(ready_out), 0);
        @(posedge clk); #1;
        clear = 0;
        model_clear();
        idle_cycles(20);
        check("clr pulses", vcount, vexp);
        compare_all("clr");
        v = '{-5, 6, -7, 8};
        send("reseed", v, 100, 0);

        // Async reset in the middle of the pair walk.
        v = '{50, 60, 70, 80};
        start_accept(v, 90, f, ok);
        valid_in = 0;
        idle_cycles(4);
        rst_n = 0;
        #1;
        check("arst ready", longint'(ready_out), 0);
        @(posedge clk); #1;
        rst_n = 1;
        model_clear();
        idle_cycles(20);
        check("arst pulses", vcount, vexp);
        compare_all("arst");

        v = '{32767, 0, 0, 0};
        send("sat_seed", v, 256, 0);
        v = '{-32768, 0, 0, 0};
        send("sat", v, 256, 0);
`ifdef EWMA_SAT_EN
        check("sat cov00", get_cov(0, 0), 32767);
`else
        check("sat cov00", get_cov(0, 0), -512);
`endif
        check("sat mean0", get_mean(0), -32768);

        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        model_clear();
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < N; k++)
                v[k] = int'($urandom_range(0, 4000)) - 2000;
            send($sformatf("warm%0d", s), v, int'($urandom_range(0, 300)), 0);
            check($sformatf("warm%0d flag", s), longint'(warm),
                  longint'(s == 7));
        end
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                check($sformatf("sym%0d%0d", i, j), get_cov(j, i), cov_m[i][j]);

        for (int s = 0; s < 12; s++) begin
            for (int k = 0; k < N; k++)
                v[k] = int'($urandom_range(0, 65535)) - 32768;
            send($sformatf("rnd%0d", s), v,
                 (s == 3) ? 0 : int'($urandom_range(0, 511)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
